// File: rtl/FIR_types.sv
// Shared types and constants for the FIR harness output verifier:
// the expected-response vector and the verifier FSM state encoding.
package FIR_types;

    // Length and width of the reference response vector.
    localparam int N_EXP = 4;
    localparam int EXP_W = 16;

    typedef logic signed [EXP_W-1:0] array_of_N_signed_16 [N_EXP];

    // Reference response the FIR output stream is checked against, in order.
    localparam array_of_N_signed_16 EXPECTED = '{16'sd4, 16'sd14, 16'sd7, 16'sd20};

    // CHECK consumes and compares samples; DONE holds the verdict until reset.
    typedef enum logic {
        CHECK = 1'b0,
        DONE  = 1'b1
    } verifier_state_t;

endpackage

// File: rtl/fir_output_verifier_timer.sv
// Idle watchdog for the output verifier: counts cycles without an accepted
// sample and reports when the allowed idle budget has been used up.
module fir_output_verifier_timer #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic system1000,
    input  logic system1000_rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int               CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] r_count;

    // Idle count: cleared by an accepted sample, saturates at the limit.
    always_ff @(posedge system1000) begin
        if (system1000_rst) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (enable && (r_count != LIMIT)) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign expired = (r_count == LIMIT);

endmodule

// File: rtl/fir_output_verifier.sv
// Self-checking sink for the FIR harness. Accepts the filter output stream,
// compares each sample in order against EXPECTED, counts mismatches, keeps
// the first failure, and produces the done/pass verdict. A sample accepted
// on one edge is compared on the next, so every result output is registered.
module fir_output_verifier
    import FIR_types::*;
#(
    parameter int N_SAMPLES      = N_EXP,
    parameter int DATA_W         = 16,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                                system1000,
    input  logic                                system1000_rst,
    input  logic                                in_valid,
    input  logic signed [DATA_W-1:0]            in_data,
    output logic                                in_ready,
    output logic                                mismatch,
    output logic [$clog2(N_SAMPLES+1)-1:0]      err_count,
    output logic [$clog2(N_SAMPLES)-1:0]        first_err_idx,
    output logic signed [DATA_W-1:0]            first_err_got,
    output logic signed [DATA_W-1:0]            first_err_exp,
    output logic                                timeout,
    output logic                                done,
    output logic                                pass
);

    localparam int               CNT_W    = $clog2(N_SAMPLES + 1);
    localparam int               IDX_W    = $clog2(N_SAMPLES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_SAMPLES - 1);
    localparam logic [CNT_W-1:0] ERR_MAX  = CNT_W'(N_SAMPLES);

    verifier_state_t r_state;
    verifier_state_t w_next_state;

    // Input side: index of the next sample and the ready handshake.
    logic [IDX_W-1:0]          r_idx;
    logic                      r_in_ready;
    logic                      r_last_taken;

    // Compare stage: the sample accepted on the previous edge.
    logic                      r_stg_valid;
    logic signed [DATA_W-1:0]  r_stg_data;
    logic [IDX_W-1:0]          r_stg_idx;

    // Registered results.
    logic                      r_mismatch;
    logic [CNT_W-1:0]          r_err_count;
    logic [IDX_W-1:0]          r_first_err_idx;
    logic signed [DATA_W-1:0]  r_first_err_got;
    logic signed [DATA_W-1:0]  r_first_err_exp;
    logic                      r_timeout;
    logic                      r_done;
    logic                      r_pass;

    logic                      w_accept;
    logic                      w_take_last;
    logic                      w_expired;
    logic                      w_timer_enable;
    logic                      w_timeout_hit;
    logic signed [DATA_W-1:0]  w_exp_val;
    logic                      w_stg_mis;
    logic                      w_stg_last;
    logic [CNT_W-1:0]          w_err_count_next;
    logic                      w_enter_done;

    // r_in_ready is only high in CHECK before the last sample is taken, so it
    // alone gates acceptance; once the last sample is in, nothing more enters.
    assign w_accept    = in_valid && r_in_ready;
    assign w_take_last = w_accept && (r_idx == LAST_IDX);

    // The idle budget runs only while the verifier is still waiting on input.
    assign w_timer_enable = r_in_ready && !w_accept;

    fir_output_verifier_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timer (
        .system1000     (system1000),
        .system1000_rst (system1000_rst),
        .clear          (w_accept),
        .enable         (w_timer_enable),
        .expired        (w_expired)
    );

    // A sample arriving on the expiry cycle wins over the timeout.
    assign w_timeout_hit = w_expired && r_in_ready && !w_accept;

    assign w_exp_val  = DATA_W'(EXPECTED[r_stg_idx]);
    assign w_stg_mis  = r_stg_valid && (r_stg_data != w_exp_val);
    assign w_stg_last = r_stg_valid && (r_stg_idx == LAST_IDX);

    assign w_err_count_next = (w_stg_mis && (r_err_count != ERR_MAX))
                            ? r_err_count + CNT_W'(1)
                            : r_err_count;

    // Next-state logic: finish on the compared last sample or on a stall.
    always_comb begin
        // NOTE: every signal assigned here gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        w_next_state = r_state;
        case (r_state)
            CHECK: begin
                if (w_stg_last || w_timeout_hit) begin
                    w_next_state = DONE;
                end
            end
            DONE: begin
                w_next_state = DONE;
            end
            default: begin
                w_next_state = CHECK;
            end
        endcase
    end

    assign w_enter_done = (r_state == CHECK) && (w_next_state == DONE);

    // FSM state register.
    always_ff @(posedge system1000) begin
        // NOTE: state is updated with non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (system1000_rst) begin
            r_state <= CHECK;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Acceptance, compare stage, error capture and verdict registers.
    always_ff @(posedge system1000) begin
        // NOTE: every register here, including the compare stage, is reset so
        // a reset mid-stream drops any in-flight comparison.
        if (system1000_rst) begin
            r_idx           <= '0;
            r_in_ready      <= 1'b1;
            r_last_taken    <= 1'b0;
            r_stg_valid     <= 1'b0;
            r_stg_data      <= '0;
            r_stg_idx       <= '0;
            r_mismatch      <= 1'b0;
            r_err_count     <= '0;
            r_first_err_idx <= '0;
            r_first_err_got <= '0;
            r_first_err_exp <= '0;
            r_timeout       <= 1'b0;
            r_done          <= 1'b0;
            r_pass          <= 1'b0;
        end else begin
            r_in_ready  <= (w_next_state == CHECK) && !w_take_last && !r_last_taken;
            r_stg_valid <= w_accept;

            if (w_accept) begin
                r_stg_data <= in_data;
                r_stg_idx  <= r_idx;
                if (!w_take_last) begin
                    r_idx <= r_idx + IDX_W'(1);
                end
            end

            if (w_take_last) begin
                r_last_taken <= 1'b1;
            end

            r_mismatch  <= w_stg_mis;
            r_err_count <= w_err_count_next;

            // Only the first failure is kept; later ones never overwrite it.
            if (w_stg_mis && (r_err_count == '0)) begin
                r_first_err_idx <= r_stg_idx;
                r_first_err_got <= r_stg_data;
                r_first_err_exp <= w_exp_val;
            end

            if (w_timeout_hit) begin
                r_timeout <= 1'b1;
            end

            if (w_enter_done) begin
                r_done <= 1'b1;
                r_pass <= (w_err_count_next == '0) && !w_timeout_hit;
            end
        end
    end

    assign in_ready      = r_in_ready;
    assign mismatch      = r_mismatch;
    assign err_count     = r_err_count;
    assign first_err_idx = r_first_err_idx;
    assign first_err_got = r_first_err_got;
    assign first_err_exp = r_first_err_exp;
    assign timeout       = r_timeout;
    assign done          = r_done;
    assign pass          = r_pass;

endmodule

// File: tb/tb_fir_output_verifier.sv
// Scoreboard bench for fir_output_verifier. The driver computes the expected
// response of each issued sample from a simple model of the verifier's rules
// and queues it; the monitor pops and compares when it sees the result of an
// accepted sample appear.
`timescale 1ns/1ps
module tb_fir_output_verifier;

    localparam int N  = 4;
    localparam int DW = 16;
    localparam int TO = 64;
    localparam int CW = $clog2(N + 1);
    localparam int IW = $clog2(N);

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  in_valid = 1'b0;
    logic signed [DW-1:0]  in_data = '0;
    logic                  in_ready;
    logic                  mismatch;
    logic [CW-1:0]         err_count;
    logic [IW-1:0]         first_err_idx;
    logic signed [DW-1:0]  first_err_got;
    logic signed [DW-1:0]  first_err_exp;
    logic                  timeout;
    logic                  done;
    logic                  pass;

    always #5 clk = ~clk;

    fir_output_verifier #(
        .N_SAMPLES      (N),
        .DATA_W         (DW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .system1000     (clk),
        .system1000_rst (rst),
        .in_valid       (in_valid),
        .in_data        (in_data),
        .in_ready       (in_ready),
        .mismatch       (mismatch),
        .err_count      (err_count),
        .first_err_idx  (first_err_idx),
        .first_err_got  (first_err_got),
        .first_err_exp  (first_err_exp),
        .timeout        (timeout),
        .done           (done),
        .pass           (pass)
    );

    typedef struct {
        logic mis;
        int   errs;
        int   fidx;
        int   fgot;
        int   fexp;
        bit   last;
        bit   pass;
    } exp_t;

    exp_t sb_q[$];
    int   checks   = 0;
    int   failures = 0;

    // Reference model: expected vector plus running verdict state.
    int exp_vec[N] = '{4, 14, 7, 20};
    int m_idx;
    int m_errs;
    int m_fidx, m_fgot, m_fexp;
    bit m_active;

    task automatic check(input string name, input logic signed [63:0] got,
                         input logic signed [63:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%0d want=%0d at %0t", name, got, want, $time);
        end
    endtask

    task automatic model_reset();
        m_idx = 0; m_errs = 0; m_fidx = 0; m_fgot = 0; m_fexp = 0; m_active = 1;
    endtask

    // Expected outcome of a sample, if the verifier is still taking samples.
    task automatic model_push(input int v);
        exp_t e;
        if (!m_active) return;
        e.mis = (v != exp_vec[m_idx]);
        if (e.mis) begin
            if (m_errs == 0) begin
                m_fidx = m_idx; m_fgot = v; m_fexp = exp_vec[m_idx];
            end
            if (m_errs < N) m_errs++;
        end
        e.errs = m_errs; e.fidx = m_fidx; e.fgot = m_fgot; e.fexp = m_fexp;
        e.last = (m_idx == N - 1);
        e.pass = e.last && (m_errs == 0);
        m_idx++;
        if (e.last) m_active = 0;
        sb_q.push_back(e);
    endtask

    // Monitor: a handshake seen at negedge n has its result visible at n+2.
    logic [1:0] hs_pipe = 2'b00;
    exp_t       mon_e;
    always @(negedge clk) begin
        if (rst) begin
            sb_q.delete();
            hs_pipe = 2'b00;
        end else begin
            if (hs_pipe[1]) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_accept", 1, 0);
                end else begin
                    mon_e = sb_q.pop_front();
                    check("mismatch", mismatch, mon_e.mis);
                    check("err_count", err_count, mon_e.errs);
                    check("first_err_idx", first_err_idx, mon_e.fidx);
                    check("first_err_got", first_err_got, mon_e.fgot);
                    check("first_err_exp", first_err_exp, mon_e.fexp);
                    if (mon_e.last) begin
                        check("done_after_last", done, 1);
                        check("in_ready_after_last", in_ready, 0);
                        check("pass", pass, mon_e.pass);
                        check("timeout_after_last", timeout, 0);
                    end else begin
                        check("done_early", done, 0);
                    end
                end
            end else begin
                check("mismatch_idle", mismatch, 0);
            end
            hs_pipe = {hs_pipe[0], in_valid && in_ready};
        end
    end

    // Called at posedge+1; leaves reset released at posedge+1.
    task automatic do_reset();
        rst = 1'b1; in_valid = 1'b0; model_reset();
        @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_mismatch", mismatch, 0);
        check("rst_timeout", timeout, 0);
        check("rst_done", done, 0);
        check("rst_pass", pass, 0);
        check("rst_err_count", err_count, 0);
        check("rst_first_idx", first_err_idx, 0);
        check("rst_first_got", first_err_got, 0);
        check("rst_first_exp", first_err_exp, 0);
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // gaps[i] idle cycles follow sample i (ignored after the last one).
    task automatic send_stream(input int vals[$], input int gaps[$]);
        for (int i = 0; i < vals.size(); i++) begin
            model_push(vals[i]);
            in_valid = 1'b1;
            in_data  = DW'(vals[i]);
            @(posedge clk); #1;
            if (i < vals.size() - 1 && gaps[i] > 0) begin
                in_valid = 1'b0;
                repeat (gaps[i]) @(posedge clk);
                #1;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        repeat (4) @(negedge clk);
        check({tag, "_sb_drained"}, sb_q.size(), 0);
        check({tag, "_done"}, done, 1);
        @(posedge clk); #1;
    endtask

    // After done, wrong data with in_valid must leave every output unchanged.
    task automatic post_done_hold();
        logic [41:0] snap;
        @(negedge clk);
        snap = {in_ready, mismatch, err_count, first_err_idx, first_err_got,
                first_err_exp, timeout, done, pass};
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            in_valid = 1'b1;
            in_data  = DW'(16'sh7F00 + 16'($urandom_range(0, 255)));
            @(negedge clk);
            check("post_done_hold", {in_ready, mismatch, err_count, first_err_idx,
                  first_err_got, first_err_exp, timeout, done, pass}, snap);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int vals[$];
        int gaps[$];
        int edges;
        logic signed [15:0] rv;

        // All match, back to back, then post-done stimulus.
        do_reset();
        send_stream('{4, 14, 7, 20}, '{0, 0, 0});
        drain("all_match");
        check("all_match_pass", pass, 1);
        post_done_hold();

        // Single error on sample 1.
        do_reset();
        send_stream('{4, 15, 7, 20}, '{0, 0, 0});
        drain("single_err");
        check("single_err_idx", first_err_idx, 1);
        check("single_err_got", first_err_got, 15);
        check("single_err_exp", first_err_exp, 14);
        check("single_err_pass", pass, 0);

        // Multiple errors: first capture must survive later mismatches.
        do_reset();
        send_stream('{5, 14, 0, 21}, '{0, 0, 0});
        drain("multi_err");
        check("multi_err_count", err_count, 3);
        check("multi_err_idx", first_err_idx, 0);
        check("multi_err_got", first_err_got, 5);
        check("multi_err_exp", first_err_exp, 4);

        // Gapped stream, 10 idle cycles between samples.
        do_reset();
        send_stream('{4, 14, 7, 20}, '{10, 10, 10});
        drain("gapped");
        check("gapped_pass", pass, 1);

        // Last sample lands exactly on the expiry cycle: sample wins.
        do_reset();
        send_stream('{4, 14, 7, 20}, '{0, 0, TO});
        drain("edge_expiry");
        check("edge_expiry_timeout", timeout, 0);
        check("edge_expiry_pass", pass, 1);

        // Timeout: two samples then silence.
        do_reset();
        send_stream('{4, 14}, '{0});
        edges = 0;
        while (edges < TO + 20) begin
            @(posedge clk);
            edges++;
            #1;
            if (done) break;
        end
        m_active = 0;
        check("timeout_latency", edges, TO + 1);
        check("timeout_flag", timeout, 1);
        check("timeout_pass", pass, 0);
        check("timeout_in_ready", in_ready, 0);
        check("timeout_sb_drained", sb_q.size(), 0);

        // Reset mid-stream after two samples, then a clean run.
        do_reset();
        send_stream('{5, 14}, '{0});
        do_reset();
        send_stream('{4, 14, 7, 20}, '{0, 0, 0});
        drain("after_reset");
        check("after_reset_pass", pass, 1);
        check("after_reset_errs", err_count, 0);

        // Randomized streams: mixed correct/random data and random gaps.
        for (int r = 0; r < 10; r++) begin
            vals.delete();
            gaps.delete();
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 1) == 0) begin
                    vals.push_back(exp_vec[i]);
                end else begin
                    rv = 16'($urandom);
                    vals.push_back(int'(rv));
                end
                gaps.push_back(($urandom_range(0, 9) == 0) ? TO : int'($urandom_range(0, 6)));
            end
            do_reset();
            send_stream(vals, gaps);
            drain("random");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
